// File: rtl/mmio_pkg.sv
// Shared definitions for the data-memory MMIO responder.
//
// Contents:
//   - MMIO_BASE_DEFAULT : default word address of the 256-word MMIO window
//   - OFF_*             : register offsets inside the window
//   - ST_*              : bit positions inside the STATUS register
//   - BUS_ERR_DATA      : read value returned for unmapped offsets when the
//                         DMEM_BUS_ERR_EN build option is enabled
//   - mmio_reg_e        : decoded register selector, plus decode_offset()
package mmio_pkg;

    localparam logic [11:0] MMIO_BASE_DEFAULT = 12'hF00;

    localparam logic [7:0] OFF_STATUS       = 8'h00;
    localparam logic [7:0] OFF_EVT_POP      = 8'h01;
    localparam logic [7:0] OFF_TIMER_PERIOD = 8'h02;
    localparam logic [7:0] OFF_TIMER_COUNT  = 8'h03;
    localparam logic [7:0] OFF_TICK_ACK     = 8'h04;
    localparam logic [7:0] OFF_LED          = 8'h05;

    localparam int ST_NOT_EMPTY = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_TICK      = 3;
    localparam int ST_OVERFLOW  = 4;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_EVT_POP,
        REG_PERIOD,
        REG_COUNT,
        REG_TICK_ACK,
        REG_LED,
        REG_UNMAPPED
    } mmio_reg_e;

    function automatic mmio_reg_e decode_offset(input logic [7:0] off);
        case (off)
            OFF_STATUS:       return REG_STATUS;
            OFF_EVT_POP:      return REG_EVT_POP;
            OFF_TIMER_PERIOD: return REG_PERIOD;
            OFF_TIMER_COUNT:  return REG_COUNT;
            OFF_TICK_ACK:     return REG_TICK_ACK;
            OFF_LED:          return REG_LED;
            default:          return REG_UNMAPPED;
        endcase
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Processor data-memory port.
//
// Signals:
//   wren         : store strobe
//   address_dmem : word address (only [11:0] is decoded)
//   data         : store data
//   q_dmem       : load data
//
// Handshake: there is no valid/ready pair. Every cycle is an access to
// address_dmem; it is a store when wren = 1, otherwise a load whose data
// appears on q_dmem exactly one cycle later. The responder never stalls.
//
// Modports: master = processor side, slave = responder side.
interface dmem_mmio_responder_if;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;

    modport master (output wren, output address_dmem, output data, input q_dmem);
    modport slave  (input wren, input address_dmem, input data, output q_dmem);
endinterface

// File: rtl/dmem_mmio_responder_evt_fifo.sv
// evt_fifo: synchronous circular-buffer FIFO for game-input events.
//
// Ports:
//   clock, reset : posedge clock, synchronous active-low reset
//   push, din    : write din at the tail (caller guarantees ~full | pop)
//   pop          : drop the head entry (caller guarantees ~empty)
//   head         : current head entry, valid while ~empty
//   full, empty  : occupancy flags
//   count        : number of entries held, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: sits between the processor data port and RAM.
// Accesses inside the 256-word MMIO window are served by a local register
// bank (event FIFO, frame timer, LED register); all others go to RAM.
//
// Ports:
//   clock, reset  : posedge clock, synchronous active-low reset
//   bus           : processor data port (slave side)
//   ram_wEn       : RAM write enable (combinational from the bus)
//   ram_addr      : RAM word address
//   ram_dataIn    : RAM write data
//   ram_dataOut   : RAM synchronous read data
//   evt_valid     : one-cycle event strobe
//   evt_data      : event payload
//   tick_irq      : high while a timer tick is pending
//   led           : LED register
//   bus_err       : sticky unmapped-access flag
//
// Build option DMEM_BUS_ERR_EN: when defined, any access to an unmapped
// MMIO offset sets bus_err and unmapped reads return 32'hDEADBEEF; when
// undefined, unmapped reads return 0, writes are ignored, bus_err is 0.
module dmem_mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [11:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8,
    parameter int          EVT_W      = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    dmem_mmio_responder_if.slave         bus,
    output logic                         ram_wEn,
    output logic [11:0]                  ram_addr,
    output logic [31:0]                  ram_dataIn,
    input  logic [31:0]                  ram_dataOut,
    input  logic                         evt_valid,
    input  logic [EVT_W-1:0]             evt_data,
    output logic                         tick_irq,
    output logic [15:0]                  led,
    output logic                         bus_err
);

    // ---------------- decode ----------------
    logic       mmio;
    logic [7:0] offset;
    mmio_reg_e  sel;
    logic       rd_status, wr_status;
    logic       rd_evt;
    logic       wr_period, wr_ack, wr_led;

    assign mmio   = (bus.address_dmem[11:8] == MMIO_BASE[11:8]);
    assign offset = bus.address_dmem[7:0];
    assign sel    = decode_offset(offset);

    assign rd_status = mmio & ~bus.wren & (sel == REG_STATUS);
    assign wr_status = mmio &  bus.wren & (sel == REG_STATUS);
    assign rd_evt    = mmio & ~bus.wren & (sel == REG_EVT_POP);
    assign wr_period = mmio &  bus.wren & (sel == REG_PERIOD);
    assign wr_ack    = mmio &  bus.wren & (sel == REG_TICK_ACK);
    assign wr_led    = mmio &  bus.wren & (sel == REG_LED);

    assign ram_wEn    = bus.wren & ~mmio;
    assign ram_addr   = bus.address_dmem[11:0];
    assign ram_dataIn = bus.data;

    // ---------------- event FIFO ----------------
    logic                          fifo_push, fifo_pop;
    logic                          fifo_full, fifo_empty;
    logic [EVT_W-1:0]              fifo_head;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow_q;
    logic                          overflow_set;

    // A pop only happens when an entry exists before the edge, so an event
    // arriving into an empty FIFO during an EVT_POP read stays queued.
    assign fifo_pop     = rd_evt & ~fifo_empty;
    assign fifo_push    = evt_valid & (~fifo_full | fifo_pop);
    assign overflow_set = evt_valid & fifo_full & ~fifo_pop;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_evt_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (evt_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A drop in the same cycle as a STATUS write keeps overflow set.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (overflow_set) begin
            overflow_q <= 1'b1;
        end else if (wr_status) begin
            overflow_q <= 1'b0;
        end
    end

    // ---------------- frame timer ----------------
    logic [31:0] period_q, count_q, tick_total_q;
    logic        tick_pending_q;
    logic        tick;

    // A period write restarts the count and suppresses a tick that cycle.
    assign tick = (period_q != 32'd0) && (count_q == period_q - 32'd1) && !wr_period;

    always_ff @(posedge clock) begin
        if (!reset) begin
            period_q       <= '0;
            count_q        <= '0;
            tick_pending_q <= 1'b0;
            tick_total_q   <= '0;
        end else begin
            if (wr_period) begin
                period_q <= bus.data;
                count_q  <= '0;
            end else if (period_q != 32'd0) begin
                count_q <= tick ? 32'd0 : count_q + 32'd1;
            end
            // A tick landing with an ack leaves the tick pending.
            if (tick) begin
                tick_pending_q <= 1'b1;
            end else if (wr_ack) begin
                tick_pending_q <= 1'b0;
            end
            if (tick) begin
                tick_total_q <= tick_total_q + 32'd1;
            end
        end
    end

    assign tick_irq = tick_pending_q;

    // ---------------- LED ----------------
    logic [15:0] led_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            led_q <= '0;
        end else if (wr_led) begin
            led_q <= bus.data[15:0];
        end
    end

    assign led = led_q;

    // ---------------- bus error ----------------
`ifdef DMEM_BUS_ERR_EN
    logic bus_err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else if (mmio && sel == REG_UNMAPPED) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // ---------------- read path ----------------
    logic [31:0] rdata;
    logic [31:0] rdata_q;
    logic        mmio_q;

    always_comb begin
        rdata = '0;
        case (sel)
            REG_STATUS: begin
                rdata[ST_NOT_EMPTY] = ~fifo_empty;
                rdata[ST_FULL]      = fifo_full;
                rdata[ST_TICK]      = tick_pending_q;
                rdata[ST_OVERFLOW]  = overflow_q;
            end
            REG_EVT_POP: begin
                if (!fifo_empty) begin
                    rdata = {1'b1, {(31 - EVT_W){1'b0}}, fifo_head};
                end
            end
            REG_PERIOD:   rdata = period_q;
            REG_COUNT:    rdata = count_q;
            REG_TICK_ACK: rdata = tick_total_q;
            REG_LED:      rdata = {16'b0, led_q};
            default: begin
`ifdef DMEM_BUS_ERR_EN
                rdata = BUS_ERR_DATA;
`else
                rdata = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= '0;
            mmio_q  <= 1'b0;
        end else begin
            rdata_q <= mmio ? rdata : 32'd0;
            mmio_q  <= mmio;
        end
    end

    assign bus.q_dmem = mmio_q ? rdata_q : ram_dataOut;

    // Address bits above the 4K word space and the FIFO count are not used.
    logic unused_bits;
    assign unused_bits = ^{bus.address_dmem[31:12], fifo_count, rd_status};

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: a synchronous RAM model,
// load/store/event driver tasks and an expected-value queue for loads.
module tb_dmem_mmio_responder;
    import mmio_pkg::*;

    localparam logic [11:0] BASE      = 12'hF00;
    localparam logic [11:0] IDLE_ADDR = 12'h0FF;
    localparam logic [11:0] A_STATUS  = BASE | 12'h000;
    localparam logic [11:0] A_EVT     = BASE | 12'h001;
    localparam logic [11:0] A_PERIOD  = BASE | 12'h002;
    localparam logic [11:0] A_COUNT   = BASE | 12'h003;
    localparam logic [11:0] A_ACK     = BASE | 12'h004;
    localparam logic [11:0] A_LED     = BASE | 12'h005;
    localparam logic [11:0] A_UNMAP   = BASE | 12'h020;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_mmio_responder_if bus ();

    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut;
    logic        evt_valid = 1'b0;
    logic [7:0]  evt_data  = 8'h00;
    logic        tick_irq;
    logic [15:0] led;
    logic        bus_err;

    dmem_mmio_responder #(
        .MMIO_BASE  (BASE),
        .FIFO_DEPTH (8),
        .EVT_W      (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .ram_wEn     (ram_wEn),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_dataOut),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .tick_irq    (tick_irq),
        .led         (led),
        .bus_err     (bus_err)
    );

    // Synchronous RAM model, cleared while reset is low.
    logic [31:0] ram_mem [4096];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= '0;
            ram_dataOut <= '0;
        end else begin
            if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
            ram_dataOut <= ram_mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic collect();
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), bus.q_dmem, exp_q.pop_front());
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        bus.wren         = 1'b0;
        bus.address_dmem = {20'b0, IDLE_ADDR};
        bus.data         = '0;
        evt_valid        = 1'b0;
    endtask

    task automatic load_ev(input logic [11:0] a, input logic [31:0] exp, input string tag,
                           input logic ev, input logic [7:0] ed);
        @(negedge clock);
        bus.address_dmem = {20'b0, a};
        bus.wren         = 1'b0;
        evt_valid        = ev;
        evt_data         = ed;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1 check({tag, "_wen"}, {31'b0, ram_wEn}, 32'd0);
        @(posedge clock);
        #1 collect();
        idle();
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] exp, input string tag);
        load_ev(a, exp, tag, 1'b0, 8'h00);
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] d, input string tag);
        logic exp_wen;
        exp_wen = (a[11:8] != BASE[11:8]);
        @(negedge clock);
        bus.address_dmem = {20'b0, a};
        bus.wren         = 1'b1;
        bus.data         = d;
        #1 check({tag, "_wen"}, {31'b0, ram_wEn}, {31'b0, exp_wen});
        @(posedge clock);
        #1 idle();
    endtask

    task automatic push_evt(input logic [7:0] d);
        @(negedge clock);
        evt_valid = 1'b1;
        evt_data  = d;
        @(posedge clock);
        #1 evt_valid = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_q", bus.q_dmem, 32'd0);
        check("rst_led", {16'b0, led}, 32'd0);
        check("rst_irq", {31'b0, tick_irq}, 32'd0);
        check("rst_berr", {31'b0, bus_err}, 32'd0);
        load(A_STATUS, 32'h0, "rst_status");

        // RAM passthrough and an MMIO store that must not reach RAM
        store(12'h010, 32'h12345678, "ram_st");
        check("ram_addr", {20'b0, ram_addr}, {20'b0, IDLE_ADDR});
        load(12'h010, 32'h12345678, "ram_ld");
        store(A_LED, 32'hABCD1234, "led_st");
        check("led_out", {16'b0, led}, 32'h00001234);
        load(A_LED, 32'h00001234, "led_ld");
        load(12'h010, 32'h12345678, "ram_ld2");

        // Event FIFO basic
        push_evt(8'h41);
        push_evt(8'h42);
        load(A_STATUS, 32'h02, "fifo_status1");
        load(A_EVT, 32'h80000041, "pop1");
        load(A_EVT, 32'h80000042, "pop2");
        load(A_EVT, 32'h00000000, "pop_empty");
        load(A_STATUS, 32'h00, "fifo_status0");

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) push_evt(8'h50 + 8'(i));
        load(A_STATUS, 32'h16, "ovf_status");
        store(A_STATUS, 32'h0, "ovf_clr");
        load(A_STATUS, 32'h06, "ovf_cleared");
        load_ev(A_EVT, 32'h80000050, "full_poppush", 1'b1, 8'h60);
        load(A_STATUS, 32'h06, "full_kept");
        for (int i = 1; i < 8; i++) load(A_EVT, 32'h80000050 + 32'(i), "drain");
        load(A_EVT, 32'h80000060, "drain_last");
        load(A_STATUS, 32'h00, "drained");

        // Push into empty FIFO coincident with an EVT_POP read
        load_ev(A_EVT, 32'h0, "empty_poppush", 1'b1, 8'h77);
        load(A_EVT, 32'h80000077, "empty_kept");

        // Timer
        load(A_COUNT, 32'h0, "cnt_idle");
        store(A_PERIOD, 32'd4, "per_st");
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1 check("tick_early", {31'b0, tick_irq}, 32'd0);
        end
        @(posedge clock);
        #1 check("tick_rise", {31'b0, tick_irq}, 32'd1);
        load(A_ACK, 32'd1, "total1");
        store(A_ACK, 32'h0, "ack");
        check("tick_acked", {31'b0, tick_irq}, 32'd0);
        @(posedge clock);
        store(A_ACK, 32'h0, "ack_tick");
        check("tick_wins", {31'b0, tick_irq}, 32'd1);
        load(A_ACK, 32'd2, "total2");
        load(A_COUNT, 32'd1, "cnt_run");
        load(A_STATUS, 32'h08, "tick_status");
        load(A_PERIOD, 32'd4, "per_ld");

        // Reset mid-run
        push_evt(8'h01);
        push_evt(8'h02);
        push_evt(8'h03);
        load(A_STATUS, 32'h0A, "pre_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_q", bus.q_dmem, 32'd0);
        check("mid_rst_led", {16'b0, led}, 32'd0);
        check("mid_rst_irq", {31'b0, tick_irq}, 32'd0);
        load(A_STATUS, 32'h0, "mid_rst_status");
        load(A_COUNT, 32'h0, "mid_rst_count");
        load(A_PERIOD, 32'h0, "mid_rst_period");
        load(A_EVT, 32'h0, "mid_rst_evt");

        // Unmapped offset
`ifdef DMEM_BUS_ERR_EN
        load(A_UNMAP, 32'hDEADBEEF, "unmap_rd");
        check("unmap_berr", {31'b0, bus_err}, 32'd1);
`else
        load(A_UNMAP, 32'h0, "unmap_rd");
        check("unmap_berr", {31'b0, bus_err}, 32'd0);
`endif
        load(12'h010, 32'h0, "ram_after_rst");

        if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
